// File: rtl/oam_dma_ctrl.sv
// Sprite (OAM) DMA and DMC sample-fetch controller on the CPU memory bus.
// Stalls the CPU, alternates GET/PUT cycles, and lets DMC fetches preempt OAM reads.
module oam_dma_ctrl #(
    parameter logic [15:0] OAM_PORT = 16'h2004,
    parameter logic [15:0] DMA_REG  = 16'h4014
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_wdata,
    input  logic [7:0]  bus_rdata,
    input  logic        dmc_req,
    input  logic [15:0] dmc_addr,
    output logic        cpu_halt,
    output logic        bus_owner,
    output logic [15:0] bus_addr,
    output logic        bus_we,
    output logic [7:0]  bus_wdata,
    output logic        dmc_ack,
    output logic [7:0]  dmc_data,
    output logic        oam_active
);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        OAM_RD,
        OAM_WR,
        DMC_RD
    } state_t;

    state_t     state;
    state_t     nxt;
    state_t     get_slot;
    logic       phase;
    logic       q_we;
    logic       dmc_pend;
    logic [7:0] page;
    logic [7:0] index;
    logic [7:0] idx_n;
    logic       trigger;
    logic       want_dmc;

    always_comb begin
        trigger  = (cpu_addr == DMA_REG) && cpu_we && !q_we && !oam_active;
        // The ack cycle masks the still-high request so one request yields one fetch.
        want_dmc = dmc_pend || (dmc_req && !dmc_ack);
        idx_n    = (state == OAM_WR) ? index + 8'd1 : index;

        if (want_dmc)
            get_slot = DMC_RD;
        else if (oam_active)
            get_slot = OAM_RD;
        else
            get_slot = IDLE;

        nxt = state;
        case (state)
            IDLE:    if (trigger || (dmc_req && !dmc_ack)) nxt = HALT;
            HALT:    nxt = phase ? get_slot : ALIGN;
            ALIGN:   nxt = get_slot;
            OAM_RD:  nxt = OAM_WR;
            OAM_WR:  nxt = (index == 8'hFF) ? IDLE : get_slot;
            DMC_RD:  nxt = ALIGN;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= 1'b0;
            q_we       <= 1'b0;
            dmc_pend   <= 1'b0;
            page       <= '0;
            index      <= '0;
            cpu_halt   <= 1'b0;
            bus_owner  <= 1'b0;
            bus_addr   <= '0;
            bus_we     <= 1'b0;
            bus_wdata  <= '0;
            dmc_ack    <= 1'b0;
            dmc_data   <= '0;
            oam_active <= 1'b0;
        end else begin
            state <= nxt;
            phase <= ~phase;
            q_we  <= cpu_we;

            if (state == IDLE && trigger) begin
                page       <= cpu_wdata;
                index      <= '0;
                oam_active <= 1'b1;
            end
            if (state == IDLE && dmc_req && !dmc_ack)
                dmc_pend <= 1'b1;
            if (state == DMC_RD)
                dmc_pend <= 1'b0;
            if (state == OAM_WR) begin
                index <= idx_n;
                if (index == 8'hFF)
                    oam_active <= 1'b0;
            end

            // Bus outputs are registered from the upcoming state.
            cpu_halt  <= (nxt != IDLE);
            bus_owner <= (nxt != IDLE) && (nxt != HALT);
            bus_we    <= (nxt == OAM_WR);
            bus_wdata <= (nxt == OAM_WR) ? bus_rdata : '0;
            case (nxt)
                OAM_RD:  bus_addr <= {page, idx_n};
                OAM_WR:  bus_addr <= OAM_PORT;
                DMC_RD:  bus_addr <= dmc_addr;
                default: bus_addr <= '0;
            endcase

            dmc_ack <= (state == DMC_RD);
            if (state == DMC_RD)
                dmc_data <= bus_rdata;
        end
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomized bench for oam_dma_ctrl: a memory model feeds reads, and transfer-level
// rules (halt length, write stream, DMC fetch results) are checked per transfer.
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic        cpu_we;
    logic [7:0]  cpu_wdata;
    logic [7:0]  bus_rdata;
    logic        dmc_req;
    logic [15:0] dmc_addr;
    logic        cpu_halt;
    logic        bus_owner;
    logic [15:0] bus_addr;
    logic        bus_we;
    logic [7:0]  bus_wdata;
    logic        dmc_ack;
    logic [7:0]  dmc_data;
    logic        oam_active;

    oam_dma_ctrl #(.OAM_PORT(16'h2004), .DMA_REG(16'h4014)) dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_we(cpu_we),
        .cpu_wdata(cpu_wdata), .bus_rdata(bus_rdata), .dmc_req(dmc_req),
        .dmc_addr(dmc_addr), .cpu_halt(cpu_halt), .bus_owner(bus_owner),
        .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata),
        .dmc_ack(dmc_ack), .dmc_data(dmc_data), .oam_active(oam_active)
    );

    always #5 clk = ~clk;

    // Memory contents: bijective in the low address byte within any page.
    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
    endfunction

    always_comb bus_rdata = mem_f(bus_addr);

    int checks = 0;
    int failures = 0;
    int cyc, halt_cnt, oam_cnt, owner_cnt, we_cnt, ack_cnt, bad_wr;
    logic [7:0]  wr_q[$];
    int          dmc_pts[$];
    logic [15:0] dmc_src;
    logic [7:0]  last_dmc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        halt_cnt = 0; oam_cnt = 0; owner_cnt = 0; we_cnt = 0; ack_cnt = 0; bad_wr = 0;
        wr_q.delete();
    endtask

    // Advance one cycle, sample outputs mid-cycle, and act as the DMC requester.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (cpu_halt) halt_cnt++;
        if (oam_active) oam_cnt++;
        if (bus_owner) owner_cnt++;
        if (bus_we) begin
            we_cnt++;
            wr_q.push_back(bus_wdata);
            if (bus_addr != 16'h2004 || !bus_owner) bad_wr++;
        end
        if (dmc_ack) begin
            ack_cnt++;
            last_dmc = dmc_data;
            dmc_req = 1'b0;
        end
        if (bus_we && dmc_pts.size() > 0 && we_cnt == dmc_pts[0]) begin
            void'(dmc_pts.pop_front());
            dmc_req  = 1'b1;
            dmc_addr = dmc_src;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; cpu_addr = '0; cpu_we = 1'b0; cpu_wdata = '0;
        dmc_req = 1'b0; dmc_addr = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".cpu_halt"}, cpu_halt, 0);
        check({tag, ".bus_owner"}, bus_owner, 0);
        check({tag, ".bus_addr"}, bus_addr, 0);
        check({tag, ".bus_we"}, bus_we, 0);
        check({tag, ".bus_wdata"}, bus_wdata, 0);
        check({tag, ".dmc_ack"}, dmc_ack, 0);
        check({tag, ".dmc_data"}, dmc_data, 0);
        check({tag, ".oam_active"}, oam_active, 0);
    endtask

    // Trigger cycle T: the cycle after HALT (T+2) is a PUT slot when T is odd.
    task automatic wait_parity(input bit want_align);
        while ((cyc % 2 == 1) != want_align) step();
    endtask

    task automatic oam_xfer(input string tag, input logic [7:0] pg, input bit al,
                            input bit spur);
        int n, ndmc, errs, exp_halt;
        ndmc = dmc_pts.size();
        wait_parity(al);
        clear_counts();
        cpu_addr = 16'h4014; cpu_we = 1'b1; cpu_wdata = pg;
        step();
        cpu_we = 1'b0; cpu_addr = '0;
        n = 0;
        while (cpu_halt && n < 2000) begin
            if (spur && n == 100) begin
                cpu_addr = 16'h4014; cpu_we = 1'b1; cpu_wdata = ~pg;
            end
            if (spur && n == 106) begin
                cpu_we = 1'b0; cpu_addr = '0;
            end
            step();
            n++;
        end
        check({tag, ".timeout"}, n < 2000, 1);
        exp_halt = 513 + int'(al) + 2 * ndmc;
        check({tag, ".halt"}, halt_cnt, exp_halt);
        check({tag, ".oam_active"}, oam_cnt, exp_halt);
        check({tag, ".owner"}, owner_cnt, exp_halt - 1);
        check({tag, ".we_pulses"}, we_cnt, 256);
        check({tag, ".we_addr"}, bad_wr, 0);
        check({tag, ".acks"}, ack_cnt, ndmc);
        errs = 0;
        for (int i = 0; i < wr_q.size() && i < 256; i++)
            if (wr_q[i] != mem_f({pg, i[7:0]})) errs++;
        check({tag, ".wdata"}, errs, 0);
        if (ndmc > 0) check({tag, ".dmc_data"}, last_dmc, mem_f(dmc_src));
    endtask

    task automatic idle_dmc(input string tag, input bit al, input logic [15:0] a);
        int n, c;
        wait_parity(al);
        clear_counts();
        c = cyc;
        dmc_src = a; dmc_addr = a; dmc_req = 1'b1;
        step();
        n = 0;
        while (cpu_halt && n < 50) begin
            step();
            n++;
        end
        check({tag, ".timeout"}, n < 50, 1);
        check({tag, ".halt"}, halt_cnt, ((c + 2) % 2 == 0) ? 3 : 4);
        check({tag, ".acks"}, ack_cnt, 1);
        check({tag, ".we"}, we_cnt, 0);
        check({tag, ".dmc_data"}, last_dmc, mem_f(a));
        repeat (5) step();
        check({tag, ".no_refetch"}, ack_cnt, 1);
    endtask

    initial begin
        int n, k, base;
        do_reset();
        check_all_zero("reset");
        repeat (10) step();

        dmc_src = 16'hC000;
        oam_xfer("oam_get", 8'h02, 1'b0, 1'b0);
        oam_xfer("oam_put", 8'h02, 1'b1, 1'b0);
        oam_xfer("oam_spur", 8'($urandom_range(0, 255)), 1'b0, 1'b1);

        dmc_pts.push_back(16'h40);
        oam_xfer("dmc40_get", 8'h02, 1'b0, 1'b0);
        dmc_pts.push_back(16'h40);
        oam_xfer("dmc40_put", 8'h02, 1'b1, 1'b0);

        idle_dmc("idle_dmc_get", 1'b0, 16'($urandom));
        idle_dmc("idle_dmc_put", 1'b1, 16'($urandom));

        for (int it = 0; it < 4; it++) begin
            k = $urandom_range(0, 3);
            base = 0;
            for (int j = 0; j < k; j++) begin
                base += $urandom_range(1, 60);
                dmc_pts.push_back(base);
            end
            dmc_src = 16'($urandom);
            oam_xfer($sformatf("rand%0d", it), 8'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)), 1'b0);
        end

        // Reset in the middle of a transfer must abort it for good.
        wait_parity(1'b0);
        clear_counts();
        cpu_addr = 16'h4014; cpu_we = 1'b1; cpu_wdata = 8'h03;
        step();
        cpu_we = 1'b0; cpu_addr = '0;
        n = 0;
        while (we_cnt < 16'h80 && n < 1000) begin
            step();
            n++;
        end
        check("abort.reach80", we_cnt, 16'h80);
        reset = 1'b1;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        clear_counts();
        repeat (600) step();
        check("abort.we_after", we_cnt, 0);
        check("abort.halt_after", halt_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
